// File: rtl/llc_burst_adaptor.sv
// Cacheline-to-burst adaptor: carries one whole-line read or write request from the
// cache arbiter out as an in-order burst of BEAT_W transfers and reassembles read lines.
module llc_burst_adaptor #(
  parameter  int LINE_W = 256,
  parameter  int BEAT_W = 64,
  localparam int NBEATS = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [31:0]       line_addr_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int               CNT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    count_r;
  logic [31:0]         addr_r;
  logic [LINE_W-1:0]   wline_r;
  logic [LINE_W-1:0]   rline_r;
  logic                last_beat_s;

  assign last_beat_s = mem_resp_i && (count_r == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; write has priority over read when both are requested
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (line_write_i) begin
          state_s = WR_BURST;
        end else if (line_read_i) begin
          state_s = RD_BURST;
        end else begin
          state_s = IDLE;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request capture, beat counting and read-line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      addr_r  <= 32'd0;
      wline_r <= '0;
      rline_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (line_write_i) begin
            addr_r  <= line_addr_i & ADDR_MASK;
            wline_r <= line_wdata_i;
            count_r <= '0;
          end else if (line_read_i) begin
            addr_r  <= line_addr_i & ADDR_MASK;
            count_r <= '0;
          end
        end
        RD_BURST: begin
          if (mem_resp_i) begin
            rline_r[int'(count_r)*BEAT_W +: BEAT_W] <= mem_rdata_i;
            count_r <= count_r + CNT_W'(1);
          end
        end
        WR_BURST: begin
          if (mem_resp_i) begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; no line_* input reaches mem_* directly
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    line_resp_o = 1'b0;
    mem_wdata_o = '0;
    case (state_r)
      RD_BURST: mem_read_o = 1'b1;
      WR_BURST: begin
        mem_write_o = 1'b1;
        mem_wdata_o = wline_r[int'(count_r)*BEAT_W +: BEAT_W];
      end
      DONE:     line_resp_o = 1'b1;
      default: begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
      end
    endcase
  end

  assign mem_addr_o   = addr_r;
  assign line_rdata_o = rline_r;

endmodule

// File: tb/tb_llc_burst_adaptor.sv
// Directed bench for llc_burst_adaptor: a table of line requests with hand-computed
// expectations, plus hand-written reset, idle-strobe and back-to-back sequences.
module tb_llc_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;

  llc_burst_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;      // write data, or the beats memory returns for a read
    logic [15:0]  pat;       // mem_resp_i per cycle from the first burst cycle, bit 0 first
    logic [31:0]  exp_addr;
    logic         exp_wr;
  } vec_t;

  vec_t         vecs[6];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [255:0] model_rline = '0;
  longint       first_active_t;
  longint       last_strobe_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Runs one request from the IDLE-cycle negedge; returns at the negedge of the IDLE cycle after DONE
  task automatic run_burst(input vec_t v);
    int   k;
    int   t;
    logic strobe;
    line_read_i  = v.rd;
    line_write_i = v.wr;
    line_addr_i  = v.addr;
    line_wdata_i = v.line;
    @(negedge clk);
    first_active_t = $time / 10;
    chk({v.name, "/kind_wr"}, 256'(mem_write_o), 256'(v.exp_wr));
    chk({v.name, "/kind_rd"}, 256'(mem_read_o), 256'(!v.exp_wr));
    line_addr_i  = ~v.addr;
    line_wdata_i = ~v.line;
    k = 0;
    t = 0;
    while (k < 4 && t < 40) begin
      if (t > 0) @(negedge clk);
      chk({v.name, "/mem_addr"}, 256'(mem_addr_o), 256'(v.exp_addr));
      chk({v.name, "/req_active"}, 256'(v.exp_wr ? mem_write_o : mem_read_o), 256'(1'b1));
      chk({v.name, "/rd_wr_exclusive"}, 256'(mem_read_o & mem_write_o), 256'(1'b0));
      chk({v.name, "/no_early_resp"}, 256'(line_resp_o), 256'(1'b0));
      if (v.exp_wr) chk({v.name, "/wdata_beat"}, 256'(mem_wdata_o), 256'(v.line[k*64 +: 64]));
      strobe      = (t < 16) ? v.pat[t] : 1'b1;
      mem_resp_i  = strobe;
      mem_rdata_i = strobe ? v.line[k*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (strobe) begin
        k++;
        last_strobe_t = $time / 10;
      end
      t++;
    end
    if (k < 4) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s/burst_timeout actual=%0d beats required=4", v.name, k);
    end
    @(negedge clk);
    mem_resp_i = 1'b0;
    if (!v.exp_wr) model_rline = v.line;
    chk({v.name, "/resp_pulse"}, 256'(line_resp_o), 256'(1'b1));
    chk({v.name, "/done_rd_low"}, 256'(mem_read_o), 256'(1'b0));
    chk({v.name, "/done_wr_low"}, 256'(mem_write_o), 256'(1'b0));
    chk({v.name, "/rdata_line"}, line_rdata_o, model_rline);
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    @(negedge clk);
    chk({v.name, "/resp_single"}, 256'(line_resp_o), 256'(1'b0));
    chk({v.name, "/idle_quiet"}, 256'({mem_read_o, mem_write_o}), 256'(2'b00));
  endtask

  initial begin
    longint saved_strobe_t;
    int     resp_seen;

    vecs[0] = '{"rd_fast", 1'b1, 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                16'hFFFF, 32'h0000_1220, 1'b0};
    vecs[1] = '{"wr_stall", 1'b0, 1'b1, 32'h8000_0013,
                {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                 64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001},
                16'hFFE5, 32'h8000_0000, 1'b1};
    vecs[2] = '{"rd_wr_both", 1'b1, 1'b1, 32'h0000_0040,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
                16'hFFFF, 32'h0000_0040, 1'b1};
    vecs[3] = '{"rd_stall_top", 1'b1, 1'b0, 32'hFFFF_FFFF,
                {64'h8000_0000_0000_0001, 64'h7777_8888_9999_AAAA,
                 64'hCAFE_F00D_DEAD_BEEF, 64'h1357_9BDF_2468_ACE0},
                16'hFFF6, 32'hFFFF_FFE0, 1'b0};
    vecs[4] = '{"b2b_rd", 1'b1, 1'b0, 32'h2000_0020,
                {64'h0000_0000_0000_00D3, 64'h0000_0000_0000_00C2,
                 64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0},
                16'hFFFF, 32'h2000_0020, 1'b0};
    vecs[5] = '{"b2b_wr", 1'b0, 1'b1, 32'h2000_003F,
                {64'h9999_0000_0000_0003, 64'h9999_0000_0000_0002,
                 64'h9999_0000_0000_0001, 64'h9999_0000_0000_0000},
                16'hFFFF, 32'h2000_0020, 1'b1};

    rst          = 1'b1;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    line_addr_i  = 32'h0;
    line_wdata_i = '0;
    mem_rdata_i  = 64'h0;
    mem_resp_i   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset/ctrl", 256'({line_resp_o, mem_read_o, mem_write_o}), 256'(3'b000));
    chk("reset/mem_addr", 256'(mem_addr_o), 256'(32'h0));
    chk("reset/mem_wdata", 256'(mem_wdata_o), 256'(64'h0));
    chk("reset/line_rdata", line_rdata_o, 256'(0));

    // Strobes while IDLE must be ignored entirely
    for (int i = 0; i < 3; i++) begin
      mem_resp_i  = 1'b1;
      mem_rdata_i = 64'hEEEE_EEEE_0000_0000 | 64'(i);
      @(negedge clk);
      chk("idle_strobe/ctrl", 256'({line_resp_o, mem_read_o, mem_write_o}), 256'(3'b000));
      chk("idle_strobe/rdata", line_rdata_o, model_rline);
    end
    mem_resp_i = 1'b0;

    for (int i = 0; i < 3; i++) run_burst(vecs[i]);

    // Reset after two read beats abandons the burst and clears partial data
    line_read_i = 1'b1;
    line_addr_i = 32'h0000_0100;
    @(negedge clk);
    mem_resp_i  = 1'b1;
    mem_rdata_i = 64'h5555_0000_0000_0001;
    @(negedge clk);
    mem_rdata_i = 64'h5555_0000_0000_0002;
    @(negedge clk);
    mem_resp_i = 1'b0;
    chk("rst_mid/partial", line_rdata_o[127:0],
        128'h5555_0000_0000_0002_5555_0000_0000_0001);
    rst         = 1'b1;
    line_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid/mem_read", 256'(mem_read_o), 256'(1'b0));
    chk("rst_mid/rdata_cleared", line_rdata_o, 256'(0));
    model_rline = '0;
    resp_seen   = 0;
    for (int i = 0; i < 6; i++) begin
      if (line_resp_o) resp_seen++;
      @(negedge clk);
    end
    chk("rst_mid/no_resp", 256'(resp_seen), 256'(0));

    run_burst(vecs[3]);

    // Back-to-back: second request is presented in the IDLE cycle right after DONE
    run_burst(vecs[4]);
    saved_strobe_t = last_strobe_t;
    run_burst(vecs[5]);
    chk("b2b/gap_cycles", 256'(first_active_t - saved_strobe_t - 1), 256'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
